// File: rtl/store_merge_ctrl_pkg.sv
// Shared definitions for the store-path controller: store size encodings,
// controller states and the alignment rule that decides whether a store faults.
package store_merge_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    DONE,
    FAULT
  } state_e;

  // A store faults if its size code is illegal or its address is not naturally aligned.
  function automatic logic is_fault(logic [1:0] size, logic [1:0] byte_off);
    return (size == SZ_ILL) ||
           ((size == SZ_WORD) && (byte_off != 2'b00)) ||
           ((size == SZ_HALF) && byte_off[0]);
  endfunction

endpackage

// File: rtl/store_merge_ctrl_if.sv
// Request and data-memory bundle for the store controller. The master side issues
// store requests and models the memory; the slave side is the controller.
interface store_merge_ctrl_if;

  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        misalign_exc;

  modport master (
    output start, size, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, misalign_exc
  );

  modport slave (
    input  start, size, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, misalign_exc
  );

endinterface

// File: rtl/store_merge_ctrl_byte_lane_merge.sv
// Combinational merge of store data into a word read from memory: SW replaces the
// whole word, SH one half selected by byte_off[1], SB one little-endian byte lane.
module byte_lane_merge
  import store_merge_ctrl_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  input  size_e       size,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged
);

  always_comb begin
    merged = rd_word;
    case (size)
      SZ_WORD: merged = wdata;
      SZ_HALF: begin
        if (byte_off[1]) merged[31:16] = wdata[15:0];
        else             merged[15:0]  = wdata[15:0];
      end
      SZ_BYTE: begin
        case (byte_off)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      default: merged = rd_word;
    endcase
  end

endmodule

// File: rtl/store_merge_ctrl.sv
// Store-path controller: executes SW directly and SH/SB as read-modify-write against
// a word-wide data memory, reporting misaligned or illegal stores as a fault.
module store_merge_ctrl
  import store_merge_ctrl_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input logic           clk,
  input logic           reset,
  store_merge_ctrl_if.slave bus
);

  localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  state_e             state;
  size_e              size_q;
  logic [1:0]         byte_off_q;
  logic [31:0]        wdata_q;
  logic [31:0]        rd_q;
  logic [CNT_W-1:0]   lat_cnt;
  logic [31:0]        merged;

  byte_lane_merge u_merge (
    .rd_word  (rd_q),
    .wdata    (wdata_q),
    .size     (size_q),
    .byte_off (byte_off_q),
    .merged   (merged)
  );

  // Write data is a pure function of captured registers, so it is stable during WRITE.
  assign bus.mem_wdata = merged;
  assign bus.busy      = (state != IDLE);

  // Strobes are set on the transition into the state that owns them and cleared by default.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      size_q           <= SZ_WORD;
      byte_off_q       <= 2'b00;
      wdata_q          <= 32'd0;
      rd_q             <= 32'd0;
      lat_cnt          <= '0;
      bus.mem_addr     <= 32'd0;
      bus.mem_wr       <= 1'b0;
      bus.done         <= 1'b0;
      bus.misalign_exc <= 1'b0;
    end else begin
      bus.mem_wr       <= 1'b0;
      bus.done         <= 1'b0;
      bus.misalign_exc <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            size_q       <= size_e'(bus.size);
            byte_off_q   <= bus.addr[1:0];
            wdata_q      <= bus.wdata;
            bus.mem_addr <= {bus.addr[31:2], 2'b00};
            lat_cnt      <= '0;
            if (is_fault(bus.size, bus.addr[1:0])) begin
              state            <= FAULT;
              bus.done         <= 1'b1;
              bus.misalign_exc <= 1'b1;
            end else if (bus.size == SZ_WORD) begin
              state      <= WRITE;
              bus.mem_wr <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end
        READ: begin
          // Address is held READ_LATENCY+1 cycles; the word is valid on the last one.
          if (lat_cnt == CNT_W'(READ_LATENCY)) begin
            rd_q       <= bus.mem_rdata;
            state      <= WRITE;
            bus.mem_wr <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          state    <= DONE;
          bus.done <= 1'b1;
        end
        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_store_merge_ctrl.sv
// Self-checking bench for store_merge_ctrl: directed cases plus randomized stores
// compared against a word-level memory model with mask-and-shift merging.
module tb_store_merge_ctrl;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  store_merge_ctrl_if bus();

  store_merge_ctrl #(.READ_LATENCY(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [31:0] dut_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  int checks   = 0;
  int failures = 0;

  // Memory seen by the DUT: one-cycle read latency, writes on the strobe.
  always @(posedge clk) begin
    if (bus.mem_wr) dut_mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
    bus.mem_rdata <= dut_mem[bus.mem_addr[11:2]];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelStore(logic [1:0] sz, logic [31:0] a, logic [31:0] w, logic [31:0] old);
    int sh;
    case (sz)
      2'd0: return w;
      2'd1: begin
        sh = 16 * int'(a[1]);
        return (old & ~(32'h0000FFFF << sh)) | ((w & 32'h0000FFFF) << sh);
      end
      2'd2: begin
        sh = 8 * int'(a[1:0]);
        return (old & ~(32'h000000FF << sh)) | ((w & 32'h000000FF) << sh);
      end
      default: return old;
    endcase
  endfunction

  task automatic setWord(input int idx, input logic [31:0] val);
    dut_mem[idx] = val;
    ref_mem[idx] = val;
  endtask

  task automatic scrambleInputs();
    bus.size  = 2'($urandom_range(0, 3));
    bus.addr  = $urandom;
    bus.wdata = $urandom;
  endtask

  // Issue one store, watch ten cycles and compare against the model.
  task automatic applyStimulus(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w, input bit spurious);
    bit          exp_fault;
    int          exp_done;
    logic [31:0] exp_data;
    int wr_cnt, done_cnt, exc_cnt, clash_cnt, done_cyc, wr_cyc;
    logic [31:0] wr_addr, wr_data;
    logic busy1;

    exp_fault = (sz == 2'd3) || (sz == 2'd0 && a[1:0] != 2'b00) || (sz == 2'd1 && a[0]);
    exp_done  = exp_fault ? 1 : ((sz == 2'd0) ? 2 : 4);
    exp_data  = modelStore(sz, a, w, ref_mem[a[11:2]]);

    @(negedge clk);
    bus.start = 1'b1;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = w;
    wr_cnt = 0; done_cnt = 0; exc_cnt = 0; clash_cnt = 0; done_cyc = 0; wr_cyc = 0;
    wr_addr = 32'd0; wr_data = 32'd0; busy1 = 1'b0;

    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = spurious && (exp_done == 4) && (c == 2 || c == 3);
      scrambleInputs();
      #1;
      if (c == 1) busy1 = bus.busy;
      if (bus.mem_wr) begin
        wr_cnt++;
        wr_cyc  = c;
        wr_addr = bus.mem_addr;
        wr_data = bus.mem_wdata;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (bus.misalign_exc) exc_cnt++;
      if (bus.mem_wr && (bus.done || bus.misalign_exc)) clash_cnt++;
    end

    checkOutput("busy_first_cycle", 32'(busy1), 32'd1);
    checkOutput("done_cycle", 32'(done_cyc), 32'(exp_done));
    checkOutput("done_count", 32'(done_cnt), 32'd1);
    checkOutput("exc_count", 32'(exc_cnt), exp_fault ? 32'd1 : 32'd0);
    checkOutput("write_count", 32'(wr_cnt), exp_fault ? 32'd0 : 32'd1);
    checkOutput("strobe_clash", 32'(clash_cnt), 32'd0);
    checkOutput("busy_after", 32'(bus.busy), 32'd0);
    checkOutput("mem_addr_hold", bus.mem_addr, {a[31:2], 2'b00});
    if (!exp_fault) begin
      checkOutput("write_cycle", 32'(wr_cyc), 32'(exp_done - 1));
      checkOutput("write_addr", wr_addr, {a[31:2], 2'b00});
      checkOutput("write_data", wr_data, exp_data);
      ref_mem[a[11:2]] = exp_data;
    end
    checkOutput("mem_word", dut_mem[a[11:2]], ref_mem[a[11:2]]);
  endtask

  // Start a store, assert reset during cycle at_cycle and confirm nothing completes.
  task automatic resetDuring(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w, input int at_cycle);
    int wr_cnt, done_cnt;
    @(negedge clk);
    bus.start = 1'b1;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = w;
    for (int c = 1; c <= at_cycle; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    checkOutput("pre_reset_wr", 32'(bus.mem_wr), (at_cycle == 3) ? 32'd1 : 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_mem_wr", 32'(bus.mem_wr), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_done", 32'(bus.done), 32'd0);
    checkOutput("abort_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("abort_mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wr_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (bus.mem_wr) wr_cnt++;
      if (bus.done) done_cnt++;
    end
    checkOutput("abort_write_count", 32'(wr_cnt), 32'd0);
    checkOutput("abort_done_count", 32'(done_cnt), 32'd0);
    checkOutput("abort_mem_word", dut_mem[a[11:2]], ref_mem[a[11:2]]);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.size  = 2'd0;
    bus.addr  = 32'd0;
    bus.wdata = 32'd0;
    for (int i = 0; i < 1024; i++) setWord(i, $urandom);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_mem_addr", bus.mem_addr, 32'd0);
    checkOutput("reset_mem_wdata", bus.mem_wdata, 32'd0);
    checkOutput("reset_mem_wr", 32'(bus.mem_wr), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_done", 32'(bus.done), 32'd0);
    checkOutput("reset_exc", 32'(bus.misalign_exc), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    applyStimulus(2'd0, 32'h100, 32'hDEADBEEF, 1'b0);
    checkOutput("sw_directed_word", dut_mem[32'h100 >> 2], 32'hDEADBEEF);
    setWord(32'h200 >> 2, 32'h11223344);
    applyStimulus(2'd2, 32'h203, 32'h000000AA, 1'b1);
    checkOutput("sb_directed_word", dut_mem[32'h200 >> 2], 32'hAA223344);
    setWord(32'h300 >> 2, 32'h11223344);
    applyStimulus(2'd1, 32'h302, 32'h0000BEEF, 1'b0);
    checkOutput("sh_hi_directed_word", dut_mem[32'h300 >> 2], 32'hBEEF3344);
    setWord(32'h300 >> 2, 32'h11223344);
    applyStimulus(2'd1, 32'h300, 32'h0000BEEF, 1'b0);
    checkOutput("sh_lo_directed_word", dut_mem[32'h300 >> 2], 32'h1122BEEF);
    applyStimulus(2'd0, 32'h101, 32'h12345678, 1'b0);
    applyStimulus(2'd1, 32'h301, 32'h0000CAFE, 1'b0);
    applyStimulus(2'd3, 32'h300, 32'hFFFFFFFF, 1'b0);

    resetDuring(2'd2, 32'h203, 32'h00000055, 1);
    applyStimulus(2'd0, 32'h104, 32'hA5A5F00D, 1'b0);
    resetDuring(2'd1, 32'h302, 32'h00001234, 3);
    applyStimulus(2'd2, 32'h301, 32'h000000C3, 1'b1);

    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 32'($urandom_range(0, 4095));
      applyStimulus(sz, a, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
